// File: rtl/float_subtractor_bf16_seq.sv
// Multi-cycle bf16 subtractor: y = a - b, flush-to-zero, round-to-nearest-even.
// One operation in flight; NORM shifts one bit per cycle.
module float_subtractor_bf16_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE
  } state_t;

  state_t state_q, state_d;

  logic              sa_q, sb_q, s_q, nan_q;
  logic signed [9:0] ea_q, eb_q, e_q;
  logic [11:0]       ma_q, mb_q, m_q;

  logic              a_big;
  logic [9:0]        ediff;
  logic [3:0]        sh;
  logic [11:0]       small_m, lost, aligned;
  logic              norm_exit;
  logic              up;
  logic [8:0]        rnd;
  logic [6:0]        frac;
  logic signed [9:0] e_r;
  logic [15:0]       y_next;

  // Mantissa layout: {carry, hidden, frac[6:0], guard, round, sticky}
  always_comb begin
    a_big   = (ea_q >= eb_q);
    ediff   = a_big ? 10'(ea_q - eb_q) : 10'(eb_q - ea_q);
    sh      = (ediff > 10'd11) ? 4'd11 : ediff[3:0];
    small_m = a_big ? mb_q : ma_q;
    lost    = small_m & ~(12'hFFF << sh);
    aligned = (small_m >> sh) | {11'd0, |lost};
  end

  always_comb begin
    norm_exit = nan_q || (m_q == 12'd0) || (e_q <= 10'sd0) ||
                (!m_q[11] && m_q[10]);
  end

  always_comb begin
    up  = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    rnd = m_q[11:3] + {8'd0, up};
    if (rnd[8]) begin
      frac = rnd[7:1];
      e_r  = e_q + 10'sd1;
    end else begin
      frac = rnd[6:0];
      e_r  = e_q;
    end
    if (nan_q)
      y_next = 16'h7FC0;
    else if (m_q == 12'd0)
      y_next = 16'h0000;
    else if (e_r >= 10'sd255)
      y_next = {s_q, 8'hFF, 7'd0};
    else
      y_next = {s_q, e_r[7:0], frac};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = ALIGN;
      ALIGN:   state_d = ADDSUB;
      ADDSUB:  state_d = NORM;
      NORM:    if (norm_exit) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      s_q   <= 1'b0;
      nan_q <= 1'b0;
      ea_q  <= '0;
      eb_q  <= '0;
      e_q   <= '0;
      ma_q  <= '0;
      mb_q  <= '0;
      m_q   <= '0;
      y     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          sa_q  <= a[15];
          sb_q  <= ~b[15];
          ea_q  <= {2'b00, a[14:7]};
          eb_q  <= {2'b00, b[14:7]};
          ma_q  <= (a[14:7] == 8'd0) ? 12'd0 : {2'b01, a[6:0], 3'd0};
          mb_q  <= (b[14:7] == 8'd0) ? 12'd0 : {2'b01, b[6:0], 3'd0};
          nan_q <= (a[14:7] == 8'hFF) || (b[14:7] == 8'hFF);
        end
        ALIGN: begin
          if (a_big) begin
            mb_q <= aligned;
            e_q  <= ea_q;
          end else begin
            ma_q <= aligned;
            e_q  <= eb_q;
          end
        end
        ADDSUB: begin
          if (sa_q == sb_q) begin
            m_q <= ma_q + mb_q;
            s_q <= sa_q;
          end else if (ma_q > mb_q) begin
            m_q <= ma_q - mb_q;
            s_q <= sa_q;
          end else if (mb_q > ma_q) begin
            m_q <= mb_q - ma_q;
            s_q <= sb_q;
          end else begin
            m_q <= 12'd0;
            s_q <= 1'b0;
          end
        end
        NORM: begin
          if (nan_q) begin
            m_q <= m_q;
          end else if (m_q == 12'd0) begin
            s_q <= 1'b0;
          end else if (e_q <= 10'sd0) begin
            m_q <= 12'd0;
            s_q <= 1'b0;
          end else if (m_q[11]) begin
            m_q <= {1'b0, m_q[11:2], m_q[1] | m_q[0]};
            e_q <= e_q + 10'sd1;
          end else if (!m_q[10]) begin
            m_q <= {m_q[10:0], 1'b0};
            e_q <= e_q - 10'sd1;
          end
        end
        ROUND:   y <= y_next;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

endmodule

// File: doc/float_subtractor_bf16_seq.md
FLOAT_SUBTRACTOR_BF16_SEQ -- requirements
Module: float_subtractor_bf16_seq

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on clock.
REQ-004 a  input  16  bf16 minuend: sign [15], exponent [14:7], fraction [6:0].
REQ-005 b  input  16  bf16 subtrahend, same format.
REQ-006 in_valid  input  1  a/b valid this cycle.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 y  output  16  bf16 result of a - b, stable while out_valid is high.
REQ-009 out_valid  output  1  y valid.
REQ-010 out_ready  input  1  consumer accepts y.

Function
REQ-011 SHALL use states IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE; one operation in flight.
REQ-012 in_ready SHALL be high only in IDLE; in_valid && in_ready at an edge captures a and b and moves to ALIGN.
REQ-013 Transitions: ALIGN->ADDSUB->NORM, 1 cycle each; NORM->ROUND when normalized, zero, or underflowed; ROUND->DONE; DONE->IDLE on out_ready, otherwise hold.
REQ-014 out_valid SHALL be high exactly in DONE; y and out_valid held unchanged until out_ready.
REQ-015 Latency from capture edge to first out_valid cycle SHALL be 4 + N edges, N = NORM left shifts (0..10); min 4, max 14.
REQ-016 Inputs with exponent 0 (zero/subnormal) SHALL be treated as zero (flush-to-zero).
REQ-017 b's sign SHALL be inverted at capture; the operation is then signed-magnitude addition.
REQ-018 Datapath: 12-bit mantissa {carry, hidden, 7 fraction bits, guard, round, sticky}; hidden bit at position 10.
REQ-019 ALIGN: smaller-exponent operand shifted right by the exponent difference, capped at 11; all shifted-out bits ORed into sticky; result exponent = larger exponent.
REQ-020 ADDSUB: same effective signs -> add; differing -> larger magnitude minus smaller; result sign = sign of larger magnitude; equal magnitudes -> +0.
REQ-021 NORM, one action per cycle: carry bit set -> right shift 1 (sticky preserved), exponent +1; else hidden bit clear and mantissa nonzero -> left shift 1, exponent -1; else exit.
REQ-022 NORM: exponent reaching 0 SHALL flush result to +0 (0x0000) and exit; zero mantissa SHALL exit with +0.
REQ-023 ROUND: round-to-nearest-even on guard/round/sticky; rounding carry out of the hidden bit SHALL renormalize (shift right, exponent +1) in the same cycle.
REQ-024 Exponent >= 255 after NORM or ROUND SHALL give signed infinity (0x7F80 / 0xFF80).
REQ-025 Either input exponent 255 SHALL give canonical NaN 0x7FC0 in DONE, same latency as N = 0.
REQ-026 Internal exponent SHALL be at least 10 bits signed so that +1/-1 steps never wrap.
REQ-027 in_valid while busy SHALL be ignored; no operand is captured.

Reset
REQ-028 Reset high at an edge SHALL force IDLE, in_ready = 1, out_valid = 0, y = 0x0000 and clear all datapath registers, from any state including mid-NORM and DONE.
REQ-029 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-030 a=0x4040 (3.0), b=0x3F80 (1.0), out_ready=1 -> y=0x4000, out_valid on the 4th edge after capture, one cycle.
REQ-031 a=0x3F80, b=0x3F80 -> y=0x0000; a=0x3F80, b=0xBF80 -> y=0x4000 (carry right-shift path).
REQ-032 a=0x3F80, b=0x3F81 -> y=0xBC00 after 7 NORM shifts, out_valid on the 11th edge after capture.
REQ-033 a=0x7F7F, b=0xFF7F -> y=0x7F80; a=0x7F80, b=any -> y=0x7FC0.
REQ-034 out_ready=0 for 5 cycles in DONE -> y/out_valid stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE next edge.
REQ-035 Reset asserted during NORM of REQ-032 -> next edge IDLE, out_valid=0, y=0x0000; a following 3.0-1.0 operation gives 0x4000.
